// File: rtl/inst_fetch_seq.sv
// Instruction fetch sequencer: walks the four byte addresses of each 32-bit word,
// assembles it little-endian and presents it to decode with a valid/ready handshake.
module inst_fetch_seq #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              misalign_err
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_ERR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [1:0]        byte_cnt_q;
   logic [31:0]       inst_q;
   logic [ADDR_W-1:0] inst_pc_q;
   logic              inst_valid_q;
   logic [ADDR_W-1:0] addr_hold_q;
   logic              misalign_q;

   logic              redir_ok;
   logic              redir_bad;
   logic              accept;
   logic [ADDR_W-1:0] fetch_addr;

   // ERR is terminal: redirects are ignored there until reset.
   assign redir_ok   = redirect_valid && (state_q != S_ERR);
   assign redir_bad  = redir_ok && (redirect_pc[1:0] != 2'b00);
   assign accept     = (state_q == S_HOLD) && inst_valid_q && inst_ready;
   assign fetch_addr = pc_q + ADDR_W'(byte_cnt_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (redir_ok) begin
         if (redir_bad)     state_d = S_ERR;
         else if (fetch_en) state_d = S_FETCH;
         else               state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (fetch_en) state_d = S_FETCH;
            S_FETCH: if (byte_cnt_q == 2'd3) state_d = S_HOLD;
            S_HOLD:  if (accept) state_d = fetch_en ? S_FETCH : S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_rd_en = (state_q == S_FETCH);
      mem_addr  = (state_q == S_FETCH) ? fetch_addr : addr_hold_q;
   end

   assign inst         = inst_q;
   assign inst_pc      = inst_pc_q;
   assign inst_valid   = inst_valid_q;
   assign misalign_err = misalign_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q         <= RESET_PC;
         byte_cnt_q   <= 2'd0;
         inst_q       <= 32'd0;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
         addr_hold_q  <= '0;
         misalign_q   <= 1'b0;
      end else begin
         if (state_q == S_FETCH) addr_hold_q <= fetch_addr;
         // Redirect wins over everything, including a coincident accept in HOLD.
         if (redir_ok) begin
            pc_q         <= redirect_pc;
            byte_cnt_q   <= 2'd0;
            inst_valid_q <= 1'b0;
            if (redir_bad) misalign_q <= 1'b1;
         end else begin
            case (state_q)
               S_IDLE: byte_cnt_q <= 2'd0;
               S_FETCH: begin
                  inst_q[{byte_cnt_q, 3'b000} +: 8] <= mem_rdata;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     inst_valid_q <= 1'b1;
                     inst_pc_q    <= pc_q;
                  end
               end
               S_HOLD: begin
                  if (accept) begin
                     inst_valid_q <= 1'b0;
                     pc_q         <= pc_q + ADDR_W'(4);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
